repetition_protected_register: RTL and testbench

Storage stage that holds one data word as REPETITION copies, packed in the layout the repetition corrector expects (copy 0 in the top DATA_WIDTH bits). It feeds its stored block through a majority vote every cycle, presenting the corrected word and an error flag. An optional scrub state machine writes the voted value back over all copies and counts the scrub events. It is the sequential stage directly downstream of the encoder and upstream of consumers of corrected data, for configuration and status registers that need upset tolerance.

---
 rtl/repetition_protected_register.sv | 110 +++++++++++
 tb/tb_repetition_protected_register.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/repetition_protected_register.sv
// Purpose: holds one word as REPETITION copies, majority-votes them every cycle, optionally scrubs (REPETITION_PROTECTED_REGISTER_SCRUB_EN).
// Latency: writes and votes visible right after the write edge; a scrub commits two edges after the upset.
// Backpressure: none, writes are always accepted and abort any scrub that is in progress.
module repetition_protected_register #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    REPETITION    = 3,
    parameter int                    COUNTER_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic                             clock,
    input  logic                             resetn,
    input  logic                             write_enable,
    input  logic [DATA_WIDTH-1:0]            write_data,
    input  logic                             inject_enable,
    input  logic [REPETITION*DATA_WIDTH-1:0] inject_mask,
    input  logic                             clear_count,
    output logic [DATA_WIDTH-1:0]            read_data,
    output logic                             error,
    output logic                             scrubbing,
    output logic [COUNTER_WIDTH-1:0]         error_count
);
    localparam int BW = REPETITION * DATA_WIDTH;
    localparam int OW = $clog2(REPETITION + 1);

    logic [BW-1:0]            block_q, block_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic [OW-1:0]            ones;
    logic                     scrub_commit;
    logic                     count_event;

    // Per-bit population count across copies; copy 0 lives in the top slice.
    always_comb begin
        read_data = '0;
        error     = 1'b0;
        ones      = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            ones = '0;
            for (int k = 0; k < REPETITION; k++) begin
                ones = ones + OW'(block_q[(REPETITION-1-k)*DATA_WIDTH + i]);
            end
            read_data[i] = (ones > OW'(REPETITION / 2));
            error        = error | ((ones != '0) && (ones != OW'(REPETITION)));
        end
    end

`ifdef REPETITION_PROTECTED_REGISTER_SCRUB_EN
    typedef enum logic {S_IDLE, S_SCRUB} state_t;
    state_t state_q, state_d;

    always_comb begin
        state_d      = state_q;
        scrub_commit = 1'b0;
        case (state_q)
            S_IDLE:  if (error && !write_enable) state_d = S_SCRUB;
            S_SCRUB: begin
                scrub_commit = !write_enable;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    assign count_event = scrub_commit;
    assign scrubbing   = (state_q == S_SCRUB);
`else
    logic error_q, error_d;

    always_comb begin
        error_d      = error;
        scrub_commit = 1'b0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) error_q <= 1'b0;
        else         error_q <= error_d;
    end

    // Without scrubbing the error persists until rewritten, so count only its onset.
    assign count_event = error & ~error_q;
    assign scrubbing   = 1'b0;
`endif

    always_comb begin
        if (write_enable)      block_d = {REPETITION{write_data}};
        else if (scrub_commit) block_d = {REPETITION{read_data}};
        else                   block_d = block_q;
        if (inject_enable) block_d = block_d ^ inject_mask;

        count_d = count_q;
        if (clear_count)                      count_d = '0;
        else if (count_event && ~&count_q)    count_d = count_q + 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            block_q <= {REPETITION{RESET_VALUE}};
            count_q <= '0;
        end else begin
            block_q <= block_d;
            count_q <= count_d;
        end
    end

    assign error_count = count_q;
endmodule

// File: tb/tb_repetition_protected_register.sv
// Scoreboard bench: a cycle model pushes expected outputs per driven cycle; they are popped and compared after the edge.
module tb_repetition_protected_register;
    localparam int DW = 8;
    localparam int R  = 3;
    localparam int CW = 8;
    localparam logic [DW-1:0] RV = 8'hA5;

    logic          clock = 1'b0;
    logic          resetn;
    logic          write_enable, inject_enable, clear_count;
    logic [DW-1:0] write_data;
    logic [R*DW-1:0] inject_mask;
    logic [DW-1:0] read_data;
    logic          error, scrubbing;
    logic [CW-1:0] error_count;

    repetition_protected_register #(
        .DATA_WIDTH(DW), .REPETITION(R), .COUNTER_WIDTH(CW), .RESET_VALUE(RV)
    ) dut (
        .clock(clock), .resetn(resetn), .write_enable(write_enable), .write_data(write_data),
        .inject_enable(inject_enable), .inject_mask(inject_mask), .clear_count(clear_count),
        .read_data(read_data), .error(error), .scrubbing(scrubbing), .error_count(error_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] rd;
        logic          err;
        logic          scr;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [R*DW-1:0] m_block;
    logic            m_scrub;
    logic            m_err_q;
    logic [CW-1:0]   m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [DW-1:0] m_vote(input logic [R*DW-1:0] b);
        logic [DW-1:0] v;
        int n;
        for (int i = 0; i < DW; i++) begin
            n = 0;
            for (int k = 0; k < R; k++) n += int'(b[k*DW + i]);
            v[i] = (n > R / 2);
        end
        return v;
    endfunction

    function automatic logic m_err(input logic [R*DW-1:0] b);
        logic [DW-1:0] c0;
        c0 = b[R*DW-1 -: DW];
        for (int k = 1; k < R; k++)
            if (b[(R-k)*DW-1 -: DW] != c0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_block = {R{RV}};
        m_scrub = 1'b0;
        m_err_q = 1'b0;
        m_cnt   = '0;
    endtask

    task automatic model_advance(input logic we, input logic [DW-1:0] wd, input logic ie,
                                 input logic [R*DW-1:0] m, input logic clr);
        logic [DW-1:0] v;
        logic e, commit, ev, nscr;
        exp_t x;
        v = m_vote(m_block);
        e = m_err(m_block);
`ifdef REPETITION_PROTECTED_REGISTER_SCRUB_EN
        commit = m_scrub && !we;
        ev     = commit;
        nscr   = m_scrub ? 1'b0 : (e && !we);
`else
        commit  = 1'b0;
        ev      = e && !m_err_q;
        m_err_q = e;
        nscr    = 1'b0;
`endif
        if (we)          m_block = {R{wd}};
        else if (commit) m_block = {R{v}};
        if (ie) m_block = m_block ^ m;
        if (clr) m_cnt = '0;
        else if (ev && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        m_scrub = nscr;
        x.rd = m_vote(m_block); x.err = m_err(m_block); x.scr = m_scrub; x.cnt = m_cnt;
        exp_q.push_back(x);
    endtask

    task automatic step(input logic we, input logic [DW-1:0] wd, input logic ie,
                        input logic [R*DW-1:0] m, input logic clr);
        exp_t x;
        write_enable = we; write_data = wd; inject_enable = ie; inject_mask = m; clear_count = clr;
        model_advance(we, wd, ie, m, clr);
        @(posedge clock);
        #1;
        check("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("sb_read_data", read_data, x.rd);
            check("sb_error", error, x.err);
            check("sb_scrubbing", scrubbing, x.scr);
            check("sb_error_count", error_count, x.cnt);
        end
        write_enable = 0; write_data = '0; inject_enable = 0; inject_mask = '0; clear_count = 0;
    endtask

    task automatic idle(); step(0, '0, 0, '0, 0); endtask

    initial begin
        logic [DW-1:0] d;
        resetn = 1'b0; write_enable = 0; write_data = '0; inject_enable = 0;
        inject_mask = '0; clear_count = 0;
        model_reset();
        #12;
        check("reset_read_data", read_data, 8'hA5);
        check("reset_error", error, 0);
        check("reset_scrubbing", scrubbing, 0);
        check("reset_count", error_count, 0);
        resetn = 1'b1;

        // Single-copy upset on copy 1 bit 0.
        step(1, 8'h3C, 0, '0, 0);
        step(0, '0, 1, 24'h000100, 0);
        check("single_read_data", read_data, 8'h3C);
        check("single_error_rise", error, 1);
        idle();
`ifdef REPETITION_PROTECTED_REGISTER_SCRUB_EN
        check("single_scrubbing", scrubbing, 1);
        check("single_error_hold", error, 1);
        idle();
        check("single_error_clear", error, 0);
        check("single_count", error_count, 1);
        check("single_block", dut.block_q, 24'h3C3C3C);
`else
        idle();
        check("single_error_sticky", error, 1);
        check("single_count", error_count, 1);
`endif

        // Two copies flipped: majority follows the corrupted copies.
        step(1, 8'hFF, 0, '0, 0);
        step(0, '0, 1, 24'h808000, 0);
        check("double_read_data", read_data, 8'h7F);
        idle(); idle();
`ifdef REPETITION_PROTECTED_REGISTER_SCRUB_EN
        check("double_error_clear", error, 0);
        check("double_block", dut.block_q, 24'h7F7F7F);
`endif

        // Write during scrub aborts the scrub.
        step(1, 8'h00, 0, '0, 0);
        step(0, '0, 1, 24'h000001, 0);
        step(1, 8'h11, 0, '0, 0);
        check("abort_read_data", read_data, 8'h11);
        check("abort_error", error, 0);
        check("abort_scrubbing", scrubbing, 0);
        idle(); idle();

        // Saturate the event counter.
        for (int n = 0; n < 300; n++) begin
            d = 8'($urandom);
`ifdef REPETITION_PROTECTED_REGISTER_SCRUB_EN
            step(0, '0, 1, 24'h1 << $urandom_range(0, R*DW-1), 0);
            idle(); idle();
`else
            step(1, d, 1, 24'h1 << $urandom_range(0, R*DW-1), 0);
            step(1, d, 0, '0, 0);
`endif
        end
        check("saturated_count", error_count, 255);

        // Clear coinciding with an event wins.
        step(1, 8'h5A, 0, '0, 0);
        step(0, '0, 1, 24'h000400, 0);
`ifdef REPETITION_PROTECTED_REGISTER_SCRUB_EN
        idle();
`endif
        step(0, '0, 0, '0, 1);
        check("clear_with_event", error_count, 0);

        // Asynchronous reset while a scrub is pending.
        step(1, 8'h66, 0, '0, 0);
        step(0, '0, 1, 24'h020000, 0);
        idle();
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        check("areset_read_data", read_data, 8'hA5);
        check("areset_error", error, 0);
        check("areset_scrubbing", scrubbing, 0);
        check("areset_count", error_count, 0);
        @(posedge clock);
        #1;
        check("areset_no_commit", dut.block_q, 24'hA5A5A5);
        resetn = 1'b1;
        idle(); idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
